// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for a 5-stage MIPS pipeline: stalls, flushes and EX forwarding selects.
// Optional saturating perf counters are enabled with the HAZ_PERF_CNT_EN macro.
module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic [31:0]      idInstr,
  input  logic             idValid,
  input  logic             branchTaken,
  input  logic             memReady,
  output logic             pcEn,
  output logic             ifIdEn,
  output logic             ifIdFlush,
  output logic             idExEn,
  output logic             idExFlush,
  output logic             exMemEn,
  output logic [1:0]       fwdA,
  output logic [1:0]       fwdB,
  output logic [CNT_W-1:0] stallCnt,
  output logic [CNT_W-1:0] flushCnt
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BNE   = 6'h05;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       wr;
    logic       is_ld;
    logic       is_mem;
    logic [4:0] rs;
    logic [4:0] rt;
  } stage_t;

  typedef enum logic {RUN = 1'b0, MEMWAIT = 1'b1} state_t;

  state_t state, state_nxt;
  stage_t id_stage, ex_q, mem_q, wb_q;
  logic   mem_wait, load_use, advance, stall_evt, flush_evt;

  logic unused_bits;
  assign unused_bits = ^{idInstr[10:0], wb_q.is_ld, wb_q.is_mem, wb_q.rs, wb_q.rt};

  function automatic logic producer(stage_t s);
    return s.valid && s.wr && (s.dest != 5'd0);
  endfunction

  // Decode of the ID instruction; rt stays 0 when the opcode does not read it.
  always_comb begin
    id_stage       = '0;
    id_stage.valid = idValid;
    id_stage.rs    = idInstr[25:21];
    case (idInstr[31:26])
      OP_RTYPE: begin
        id_stage.rt   = idInstr[20:16];
        id_stage.dest = idInstr[15:11];
        id_stage.wr   = 1'b1;
      end
      OP_LW: begin
        id_stage.dest   = idInstr[20:16];
        id_stage.wr     = 1'b1;
        id_stage.is_ld  = 1'b1;
        id_stage.is_mem = 1'b1;
      end
      OP_SW: begin
        id_stage.rt     = idInstr[20:16];
        id_stage.is_mem = 1'b1;
      end
      OP_ADDI: begin
        id_stage.dest = idInstr[20:16];
        id_stage.wr   = 1'b1;
      end
      OP_BNE:  id_stage.rt = idInstr[20:16];
      default: ;
    endcase
  end

  assign mem_wait = mem_q.valid && mem_q.is_mem && !memReady;
  assign load_use = idValid && producer(ex_q) && ex_q.is_ld &&
                    ((ex_q.dest == id_stage.rs) || (ex_q.dest == id_stage.rt));

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= RUN;
    else       state <= state_nxt;
  end

  // Next state and priority-ordered enable/flush generation.
  always_comb begin
    state_nxt = state;
    pcEn      = 1'b1;
    ifIdEn    = 1'b1;
    ifIdFlush = 1'b0;
    idExEn    = 1'b1;
    idExFlush = 1'b0;
    exMemEn   = 1'b1;
    advance   = 1'b1;
    stall_evt = 1'b0;
    flush_evt = 1'b0;
    case (state)
      RUN:     if (mem_wait) state_nxt = MEMWAIT;
      MEMWAIT: if (memReady) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
    if ((state == MEMWAIT && !memReady) || (state == RUN && mem_wait)) begin
      pcEn      = 1'b0;
      ifIdEn    = 1'b0;
      idExEn    = 1'b0;
      exMemEn   = 1'b0;
      advance   = 1'b0;
      stall_evt = 1'b1;
    end else if (branchTaken) begin
      ifIdFlush = 1'b1;
      idExFlush = 1'b1;
      flush_evt = 1'b1;
    end else if (load_use) begin
      pcEn      = 1'b0;
      ifIdEn    = 1'b0;
      idExFlush = 1'b1;
      stall_evt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (advance) begin
      ex_q  <= idExFlush ? '0 : id_stage;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  // EX operand selects; the nearer (MEM) producer wins.
  always_comb begin
    fwdA = FWD_RF;
    fwdB = FWD_RF;
    if (ex_q.valid) begin
      if (producer(mem_q) && mem_q.dest == ex_q.rs)     fwdA = FWD_MEM;
      else if (producer(wb_q) && wb_q.dest == ex_q.rs)  fwdA = FWD_WB;
      if (producer(mem_q) && mem_q.dest == ex_q.rt)     fwdB = FWD_MEM;
      else if (producer(wb_q) && wb_q.dest == ex_q.rt)  fwdB = FWD_WB;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_evt && stall_q != '1) stall_q <= stall_q + CNT_W'(1);
      if (flush_evt && flush_q != '1) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stallCnt = stall_q;
  assign flushCnt = flush_q;
`else
  logic unused_evt;
  assign unused_evt = stall_evt ^ flush_evt;
  assign stallCnt   = '0;
  assign flushCnt   = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed hazard scenarios plus a randomized
// instruction stream checked against a pipeline-occupancy reference model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned CNT_W = 16;

  logic             clk, rstN, idValid, branchTaken, memReady;
  logic [31:0]      idInstr;
  logic             pcEn, ifIdEn, ifIdFlush, idExEn, idExFlush, exMemEn;
  logic [1:0]       fwdA, fwdB;
  logic [CNT_W-1:0] stallCnt, flushCnt;
  logic [9:0]       obs;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rstN(rstN), .idInstr(idInstr), .idValid(idValid),
    .branchTaken(branchTaken), .memReady(memReady), .pcEn(pcEn), .ifIdEn(ifIdEn),
    .ifIdFlush(ifIdFlush), .idExEn(idExEn), .idExFlush(idExFlush), .exMemEn(exMemEn),
    .fwdA(fwdA), .fwdB(fwdB), .stallCnt(stallCnt), .flushCnt(flushCnt)
  );

  assign obs = {pcEn, ifIdEn, ifIdFlush, idExEn, idExFlush, exMemEn, fwdA, fwdB};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: what each of EX/MEM/WB holds, as plain integers (rt = -1 when not read).
  typedef struct {
    bit v; int dest; bit wr; bit ld; bit mem; int rs; int rt;
  } ent_t;

  ent_t       pipe [3];
  ent_t       m_id;
  int         m_stall, m_flush;
  bit         m_adv, m_bub, m_sev, m_fev;
  logic [9:0] exp_vec;
  int         n_cmp, n_fail;

  function automatic ent_t empty_ent();
    ent_t e;
    e.v = 0; e.dest = 0; e.wr = 0; e.ld = 0; e.mem = 0; e.rs = 0; e.rt = -1;
    return e;
  endfunction

  function automatic ent_t decode(logic [31:0] ins, logic v);
    ent_t e;
    int   op;
    e    = empty_ent();
    e.v  = v;
    e.rs = int'(ins[25:21]);
    op   = int'(ins[31:26]);
    case (op)
      0:  begin e.rt = int'(ins[20:16]); e.dest = int'(ins[15:11]); e.wr = 1; end
      35: begin e.dest = int'(ins[20:16]); e.wr = 1; e.ld = 1; e.mem = 1; end
      43: begin e.rt = int'(ins[20:16]); e.mem = 1; end
      8:  begin e.dest = int'(ins[20:16]); e.wr = 1; end
      5:  e.rt = int'(ins[20:16]);
      default: ;
    endcase
    return e;
  endfunction

  function automatic bit writes_reg(ent_t e);
    return e.v && e.wr && e.dest != 0;
  endfunction

  function automatic logic [1:0] fsel(int r);
    if (!pipe[0].v) return 2'b00;
    if (writes_reg(pipe[1]) && pipe[1].dest == r) return 2'b10;
    if (writes_reg(pipe[2]) && pipe[2].dest == r) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int exp_cnt(int m);
    if (m < 0) return 0;
`ifdef HAZ_PERF_CNT_EN
    return m;
`else
    return 0;
`endif
  endfunction

  function automatic logic [31:0] r_op(int rs, int rt, int rd, logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_op(logic [5:0] op, int rs, int rt, logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] rand_instr();
    int a, b, c;
    logic [5:0] fn;
    a = int'($urandom_range(0, 7));
    b = int'($urandom_range(0, 7));
    c = int'($urandom_range(0, 7));
    case ($urandom_range(0, 4))
      0: fn = 6'h20;
      1: fn = 6'h22;
      2: fn = 6'h24;
      3: fn = 6'h25;
      default: fn = 6'h2a;
    endcase
    case ($urandom_range(0, 6))
      0: return i_op(6'h23, a, b, 16'($urandom));
      1: return i_op(6'h2b, a, b, 16'($urandom));
      2: return i_op(6'h08, a, b, 16'($urandom));
      3: return i_op(6'h05, a, b, 16'($urandom));
      4: return {6'h02, 26'($urandom)};
      default: return r_op(a, b, c, fn);
    endcase
  endfunction

  // Apply one cycle of inputs at posedge+1 and work out what the controller should do.
  task automatic drive(input logic [31:0] ins, input logic v, input logic br, input logic rdy);
    bit busy, lu;
    logic [5:0] en;
    idInstr = ins; idValid = v; branchTaken = br; memReady = rdy;
    m_id = decode(ins, v);
    busy = pipe[1].v && pipe[1].mem && !rdy;
    lu   = v && writes_reg(pipe[0]) && pipe[0].ld &&
           (pipe[0].dest == m_id.rs || pipe[0].dest == m_id.rt);
    m_adv = 1; m_bub = 0; m_sev = 0; m_fev = 0;
    if (busy)    begin en = 6'b000000; m_adv = 0; m_sev = 1; end
    else if (br) begin en = 6'b111111; m_bub = 1; m_fev = 1; end
    else if (lu) begin en = 6'b000111; m_bub = 1; m_sev = 1; end
    else         en = 6'b110101;
    exp_vec = {en, fsel(pipe[0].rs), fsel(pipe[0].rt)};
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    if (m_adv) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = m_bub ? empty_ent() : m_id;
    end
    if (m_sev && m_stall < (1 << CNT_W) - 1) m_stall++;
    if (m_fev && m_flush < (1 << CNT_W) - 1) m_flush++;
    #1;
  endtask

  task automatic do_reset();
    idInstr = '0; idValid = 0; branchTaken = 0; memReady = 1; rstN = 0;
    for (int i = 0; i < 3; i++) pipe[i] = empty_ent();
    m_stall = 0; m_flush = 0;
    @(negedge clk);
    rstN = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if (obs !== 10'b1101010000) begin
      n_fail++; $display("FAIL reset_outputs: got %b want %b", obs, 10'b1101010000);
    end
    n_cmp++;
    if (stallCnt !== '0 || flushCnt !== '0) begin
      n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", stallCnt, flushCnt);
    end
    do_reset();
  endtask

  task automatic test_no_dep();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(r_op(int'($urandom_range(1, 9)), int'($urandom_range(1, 9)),
                 int'($urandom_range(10, 19)), (i % 2 == 0) ? 6'h20 : 6'h22), 1, 0, 1);
      n_cmp++;
      if (obs !== 10'b1101010000 || obs !== exp_vec) begin
        n_fail++; $display("FAIL no_dep c%0d: got %b want %b", i, obs, exp_vec);
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    logic [31:0] lw_i, add_i;
    lw_i  = i_op(6'h23, 1, 2, 16'd0);
    add_i = r_op(2, 4, 3, 6'h20);
    do_reset();
    drive(lw_i, 1, 0, 1);
    tick();
    drive(add_i, 1, 0, 1);
    n_cmp++;
    if (obs[9:4] !== 6'b000111 || obs !== exp_vec) begin
      n_fail++; $display("FAIL load_use_stall: got %b want %b", obs, exp_vec);
    end
    tick();
    drive(add_i, 1, 0, 1);
    n_cmp++;
    if (obs[9:4] !== 6'b110101 || obs !== exp_vec) begin
      n_fail++; $display("FAIL load_use_single: got %b want %b", obs, exp_vec);
    end
    tick();
    drive(32'h0, 1, 0, 1);
    n_cmp++;
    if (fwdA !== 2'b01 || fwdB !== 2'b00 || obs !== exp_vec) begin
      n_fail++; $display("FAIL load_use_fwd: got %b want %b", obs, exp_vec);
    end
    n_cmp++;
    if (stallCnt !== CNT_W'(exp_cnt(1))) begin
      n_fail++; $display("FAIL load_use_cnt: got %0d want %0d", stallCnt, exp_cnt(1));
    end
    tick();
  endtask

  task automatic test_forward();
    do_reset();
    drive(r_op(1, 1, 2, 6'h20), 1, 0, 1); tick();
    drive(r_op(2, 2, 5, 6'h22), 1, 0, 1); tick();
    drive(32'h0, 1, 0, 1);
    n_cmp++;
    if (obs !== 10'b1101011010 || obs !== exp_vec) begin
      n_fail++; $display("FAIL fwd_mem: got %b want %b", obs, exp_vec);
    end
    tick();
    do_reset();
    drive(r_op(1, 1, 2, 6'h20), 1, 0, 1); tick();
    drive(32'h0, 1, 0, 1); tick();
    drive(r_op(2, 2, 5, 6'h22), 1, 0, 1); tick();
    drive(32'h0, 1, 0, 1);
    n_cmp++;
    if (obs !== 10'b1101010101 || obs !== exp_vec) begin
      n_fail++; $display("FAIL fwd_wb: got %b want %b", obs, exp_vec);
    end
    tick();
  endtask

  task automatic test_branch();
    do_reset();
    drive(i_op(6'h23, 1, 2, 16'd0), 1, 0, 1); tick();
    drive(r_op(2, 4, 3, 6'h20), 1, 1, 1);
    n_cmp++;
    if (obs[9:4] !== 6'b111111 || obs !== exp_vec) begin
      n_fail++; $display("FAIL branch_flush: got %b want %b", obs, exp_vec);
    end
    tick();
    drive(32'h0, 1, 0, 1);
    n_cmp++;
    if (flushCnt !== CNT_W'(exp_cnt(1)) || stallCnt !== '0) begin
      n_fail++; $display("FAIL branch_cnt: got %0d/%0d want %0d/0", flushCnt, stallCnt, exp_cnt(1));
    end
    tick();
  endtask

  task automatic test_memwait();
    do_reset();
    drive(i_op(6'h2b, 1, 3, 16'd0), 1, 0, 1); tick();
    drive(32'h0, 1, 0, 1); tick();
    for (int i = 0; i < 3; i++) begin
      drive(32'h0, 1, (i == 1), 0);
      n_cmp++;
      if (obs[9:4] !== 6'b000000 || obs !== exp_vec) begin
        n_fail++; $display("FAIL memwait_hold c%0d: got %b want %b", i, obs, exp_vec);
      end
      tick();
    end
    drive(32'h0, 1, 0, 1);
    n_cmp++;
    if (obs[9:4] !== 6'b110101 || obs !== exp_vec) begin
      n_fail++; $display("FAIL memwait_release: got %b want %b", obs, exp_vec);
    end
    n_cmp++;
    if (stallCnt !== CNT_W'(exp_cnt(3)) || flushCnt !== '0) begin
      n_fail++; $display("FAIL memwait_cnt: got %0d/%0d want %0d/0", stallCnt, flushCnt, exp_cnt(3));
    end
    tick();
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    drive(i_op(6'h2b, 1, 3, 16'd0), 1, 0, 1); tick();
    drive(32'h0, 1, 0, 1); tick();
    drive(32'h0, 1, 0, 0); tick();
    drive(32'h0, 1, 0, 0);
    n_cmp++;
    if (obs[9:4] !== 6'b000000) begin
      n_fail++; $display("FAIL rst_wait_pre: got %b want 000000", obs[9:4]);
    end
    rstN = 0;
    #1;
    n_cmp++;
    if (obs !== 10'b1101010000 || stallCnt !== '0 || flushCnt !== '0) begin
      n_fail++; $display("FAIL rst_wait_abort: got %b cnt %0d/%0d want 1101010000 cnt 0/0",
                         obs, stallCnt, flushCnt);
    end
    do_reset();
    drive(32'h0, 1, 0, 0);
    n_cmp++;
    if (obs !== 10'b1101010000 || obs !== exp_vec) begin
      n_fail++; $display("FAIL rst_wait_run: got %b want %b", obs, exp_vec);
    end
    tick();
    drive(i_op(6'h23, 1, 0, 16'd0), 1, 0, 1); tick();
    drive(r_op(0, 0, 3, 6'h20), 1, 0, 1);
    n_cmp++;
    if (obs[9:4] !== 6'b110101 || obs !== exp_vec) begin
      n_fail++; $display("FAIL zero_reg_no_stall: got %b want %b", obs, exp_vec);
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(rand_instr(), ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 9) < 7));
      n_cmp++;
      if (obs !== exp_vec) begin
        n_fail++; $display("FAIL random c%0d: got %b want %b", i, obs, exp_vec);
      end
      n_cmp++;
      if (stallCnt !== CNT_W'(exp_cnt(m_stall)) || flushCnt !== CNT_W'(exp_cnt(m_flush))) begin
        n_fail++; $display("FAIL random_cnt c%0d: got %0d/%0d want %0d/%0d", i,
                           stallCnt, flushCnt, exp_cnt(m_stall), exp_cnt(m_flush));
      end
      tick();
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    m_stall = 0; m_flush = 0;
    for (int i = 0; i < 3; i++) pipe[i] = empty_ent();
    rstN = 0; idInstr = '0; idValid = 0; branchTaken = 0; memReady = 1;
    test_reset();
    test_no_dep();
    test_load_use();
    test_forward();
    test_branch();
    test_memwait();
    test_reset_in_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
